// File: rtl/cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder
//
// Purpose:
//   Decodes a byte-oriented command stream received over UART. It turns that
//   stream into register-file writes and reads and into ALU operations. It
//   returns read data or ALU results over UART TX.
//
//   Command bytes (received in IDLE):
//     0xAA  RF write        : <addr> <data>
//     0xBB  RF read         : <addr>            -> one TX byte (read data)
//     0xCC  ALU w/ operands : <opA> <opB> <fun> -> opA to RF[0], opB to RF[1],
//                                                  two TX bytes (result lo, hi)
//     0xDD  ALU no operands : <fun>             -> two TX bytes (result lo, hi)
//   Any other byte received in IDLE is ignored.
//
// Ports:
//   CLK, RST                  clock and synchronous active-high reset
//   RX_P_DATA / RX_D_VLD      received byte and its one-cycle valid pulse
//   RF_WR_EN / RF_RD_EN       one-cycle register-file write / read strobes
//   RF_ADDR / RF_WR_DATA      register-file address and write data
//   RF_RD_DATA / RF_RD_VLD    register-file read data and its valid pulse
//   ALU_EN / ALU_FUN          ALU enable (held until result) and function
//   ALU_OUT / ALU_OUT_VLD     ALU result and its valid pulse
//   TX_P_DATA / TX_D_VLD      byte to transmit and one-cycle transmit request
//   TX_BUSY                   UART transmitter busy flag
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module cmd_frame_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY
);

    localparam logic [DATA_WIDTH-1:0] CMD_RF_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RF_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_ADDR    = 4'd1,
        WR_DATA    = 4'd2,
        RD_ADDR    = 4'd3,
        RD_WAIT    = 4'd4,
        OP_A       = 4'd5,
        OP_B       = 4'd6,
        FUN        = 4'd7,
        ALU_WAIT   = 4'd8,
        TX_B0      = 4'd9,
        TX_B0_WAIT = 4'd10,
        TX_B1      = 4'd11
    } state_t;

    state_t                  state_q,      state_d;
    logic                    rf_wr_en_q,   rf_wr_en_d;
    logic                    rf_rd_en_q,   rf_rd_en_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_q,    rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                    alu_en_q,     alu_en_d;
    logic [3:0]              alu_fun_q,    alu_fun_d;
    logic [2*DATA_WIDTH-1:0] result_q,     result_d;
    logic                    rsp_read_q,   rsp_read_d;   // response is a single RF read byte
    logic                    busy_seen_q,  busy_seen_d;  // TX_BUSY observed high after byte 0
    logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
    logic                    tx_vld_q,     tx_vld_d;

    // Next-state and next-output logic for the command decoder.
    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = alu_en_q;
        alu_fun_d    = alu_fun_q;
        result_d     = result_q;
        rsp_read_d   = rsp_read_q;
        busy_seen_d  = busy_seen_q;
        tx_data_d    = tx_data_q;   // held so TX_P_DATA stays stable between requests
        tx_vld_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_RF_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RF_RD) begin
                        state_d = RD_ADDR;
                    end else if (RX_P_DATA == CMD_ALU_OP) begin
                        state_d = OP_A;
                    end else if (RX_P_DATA == CMD_ALU_NO) begin
                        state_d = FUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = WR_DATA;
                end else begin
                    state_d   = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = IDLE;
                end else begin
                    state_d      = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = RD_WAIT;
                end else begin
                    state_d    = RD_ADDR;
                end
            end
            RD_WAIT: begin
                if (RF_RD_VLD) begin
                    result_d   = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    rsp_read_d = 1'b1;
                    state_d    = TX_B1;
                end else begin
                    state_d    = RD_WAIT;
                end
            end
            OP_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = {ADDR_WIDTH{1'b0}};
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = OP_B;
                end else begin
                    state_d      = OP_A;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(1'b1);
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = FUN;
                end else begin
                    state_d      = OP_B;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end else begin
                    state_d   = FUN;
                end
            end
            ALU_WAIT: begin
                // ALU_EN stays high until the result arrives.
                if (ALU_OUT_VLD) begin
                    result_d   = ALU_OUT;
                    rsp_read_d = 1'b0;
                    alu_en_d   = 1'b0;
                    state_d    = TX_B0;
                end else begin
                    state_d    = ALU_WAIT;
                end
            end
            TX_B0: begin
                if (!TX_BUSY) begin
                    tx_data_d   = result_q[DATA_WIDTH-1:0];
                    tx_vld_d    = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = TX_B0_WAIT;
                end else begin
                    state_d     = TX_B0;
                end
            end
            TX_B0_WAIT: begin
                // Byte 1 goes out only after the transmitter has taken byte 0
                // (busy rose) and finished it (busy fell).
                if (TX_BUSY) begin
                    busy_seen_d = 1'b1;
                    state_d     = TX_B0_WAIT;
                end else if (busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    state_d     = TX_B1;
                end else begin
                    state_d     = TX_B0_WAIT;
                end
            end
            TX_B1: begin
                if (!TX_BUSY) begin
                    tx_data_d = rsp_read_q ? result_q[DATA_WIDTH-1:0]
                                           : result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = TX_B1;
                end
            end
            default: begin
                state_d  = IDLE;
                alu_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_q <= {DATA_WIDTH{1'b0}};
            alu_en_q     <= 1'b0;
            alu_fun_q    <= 4'h0;
            result_q     <= {(2*DATA_WIDTH){1'b0}};
            rsp_read_q   <= 1'b0;
            busy_seen_q  <= 1'b0;
            tx_data_q    <= {DATA_WIDTH{1'b0}};
            tx_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            result_q     <= result_d;
            rsp_read_q   <= rsp_read_d;
            busy_seen_q  <= busy_seen_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
        end
    end

    assign RF_WR_EN   = rf_wr_en_q;
    assign RF_RD_EN   = rf_rd_en_q;
    assign RF_ADDR    = rf_addr_q;
    assign RF_WR_DATA = rf_wr_data_q;
    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_decoder
//
// Directed testbench for cmd_frame_decoder. A negedge monitor logs every
// RF write, RF read and TX byte. It also models the UART transmitter: TX_BUSY
// is held high for four cycles after each TX_D_VLD. Each test task drives
// bytes and compares the logs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cmd_frame_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [3:0]  RF_ADDR;
    logic [7:0]  RF_WR_DATA;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;

    int checks = 0;
    int errors = 0;

    logic [3:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [7:0] tx_log[$];
    int         tx_cyc_log[$];
    int         rd_cnt     = 0;
    int         excl_viol  = 0;
    int         busy_viol  = 0;
    int         cyc        = 0;
    int         busy_cnt   = 0;

    cmd_frame_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RF_WR_EN    (RF_WR_EN),
        .RF_RD_EN    (RF_RD_EN),
        .RF_ADDR     (RF_ADDR),
        .RF_WR_DATA  (RF_WR_DATA),
        .RF_RD_DATA  (RF_RD_DATA),
        .RF_RD_VLD   (RF_RD_VLD),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .TX_BUSY     (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    // Monitor and UART TX model, evaluated on the falling edge.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (RF_WR_EN === 1'b1) begin
            wr_addr_log.push_back(RF_ADDR);
            wr_data_log.push_back(RF_WR_DATA);
        end
        if (RF_RD_EN === 1'b1) rd_cnt = rd_cnt + 1;
        if (TX_D_VLD === 1'b1) begin
            tx_log.push_back(TX_P_DATA);
            tx_cyc_log.push_back(cyc);
            // TX_BUSY still holds the value the DUT saw at the last posedge.
            if (TX_BUSY === 1'b1) busy_viol = busy_viol + 1;
        end
        if ((int'(RF_WR_EN) + int'(RF_RD_EN) + int'(TX_D_VLD)) > 1) excl_viol = excl_viol + 1;
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (TX_D_VLD === 1'b1) busy_cnt = 4;
        TX_BUSY = (busy_cnt != 0);
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step();
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 10; i++) step();
        wr_addr_log.delete();
        wr_data_log.delete();
        tx_log.delete();
        tx_cyc_log.delete();
        rd_cnt = 0;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && tx_log.size() < n; i++) step();
        ok = (tx_log.size() >= n);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        checks++;
        if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD});
        end
        checks++;
        if ({RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 000000", {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA});
        end
    endtask

    task automatic test_write();
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'hF5);   // upper bits must be dropped: address 5
        send_byte(8'h77);
        checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h5, 8'h77}) begin
            errors++;
            $display("FAIL wr_pulse: got en=%b addr=%h data=%h expected en=1 addr=5 data=77", RF_WR_EN, RF_ADDR, RF_WR_DATA);
        end
        step();
        checks++;
        if (RF_WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL wr_one_cycle: got %b expected 0", RF_WR_EN);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (wr_addr_log.size() != 1 || tx_log.size() != 0) begin
            errors++;
            $display("FAIL wr_counts: got wr=%0d tx=%0d expected wr=1 tx=0", wr_addr_log.size(), tx_log.size());
        end
    endtask

    task automatic test_read();
        bit ok;
        clear_logs();
        send_byte(8'hBB);
        send_byte(8'h02);
        checks++;
        if ({RF_RD_EN, RF_ADDR} !== {1'b1, 4'h2}) begin
            errors++;
            $display("FAIL rd_pulse: got en=%b addr=%h expected en=1 addr=2", RF_RD_EN, RF_ADDR);
        end
        step();
        checks++;
        if (RF_RD_EN !== 1'b0) begin
            errors++;
            $display("FAIL rd_one_cycle: got %b expected 0", RF_RD_EN);
        end
        // Stray bytes during RD_WAIT must be dropped.
        send_byte(8'hAA);
        send_byte(8'h03);
        RF_RD_DATA = 8'h3C;
        RF_RD_VLD  = 1'b1;
        step();
        RF_RD_VLD  = 1'b0;
        RF_RD_DATA = 8'hFF;
        wait_tx(1, 50, ok);
        checks++;
        if (!ok || tx_log[0] !== 8'h3C) begin
            errors++;
            $display("FAIL rd_tx_byte: got ok=%0d byte=%h expected 3c", ok, ok ? tx_log[0] : 8'h00);
        end
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (tx_log.size() != 1 || wr_addr_log.size() != 0 || rd_cnt != 1) begin
            errors++;
            $display("FAIL rd_counts: got tx=%0d wr=%0d rd=%0d expected 1 0 1", tx_log.size(), wr_addr_log.size(), rd_cnt);
        end
        checks++;
        if (TX_P_DATA !== 8'h3C) begin
            errors++;
            $display("FAIL tx_data_stable: got %h expected 3c", TX_P_DATA);
        end
    endtask

    task automatic run_alu(input logic [3:0] fun, input logic [15:0] res, input string name);
        bit ok;
        checks++;
        if ({ALU_EN, ALU_FUN} !== {1'b1, fun}) begin
            errors++;
            $display("FAIL %s_alu_start: got en=%b fun=%h expected en=1 fun=%h", name, ALU_EN, ALU_FUN, fun);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (ALU_EN !== 1'b1) begin
            errors++;
            $display("FAIL %s_alu_hold: got %b expected 1", name, ALU_EN);
        end
        ALU_OUT     = res;
        ALU_OUT_VLD = 1'b1;
        step();
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'hFFFF;
        checks++;
        if (ALU_EN !== 1'b0) begin
            errors++;
            $display("FAIL %s_alu_drop: got %b expected 0", name, ALU_EN);
        end
        wait_tx(2, 100, ok);
        checks++;
        if (!ok || tx_log[0] !== res[7:0] || tx_log[1] !== res[15:8]) begin
            errors++;
            $display("FAIL %s_tx_bytes: got ok=%0d b0=%h b1=%h expected %h %h", name, ok,
                     ok ? tx_log[0] : 8'h00, ok ? tx_log[1] : 8'h00, res[7:0], res[15:8]);
        end
        checks++;
        if (!ok || (tx_cyc_log[1] - tx_cyc_log[0]) < 5) begin
            errors++;
            $display("FAIL %s_tx_gap: got ok=%0d gap=%0d expected >=5", name, ok,
                     ok ? (tx_cyc_log[1] - tx_cyc_log[0]) : 0);
        end
    endtask

    task automatic test_alu_ops();
        clear_logs();
        send_byte(8'hCC);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h01);
        checks++;
        if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 4'h0 || wr_data_log[0] !== 8'h05 ||
            wr_addr_log[1] !== 4'h1 || wr_data_log[1] !== 8'h03) begin
            errors++;
            $display("FAIL ops_rf_writes: got %0d writes (first %h/%h) expected (0,05),(1,03)",
                     wr_addr_log.size(), wr_addr_log.size() > 0 ? wr_addr_log[0] : 4'h0,
                     wr_data_log.size() > 0 ? wr_data_log[0] : 8'h00);
        end
        run_alu(4'h1, 16'h0008, "ops");
    endtask

    task automatic test_alu_noops();
        clear_logs();
        send_byte(8'hDD);
        send_byte(8'h02);
        run_alu(4'h2, 16'h1234, "noops");
        checks++;
        if (wr_addr_log.size() != 0) begin
            errors++;
            $display("FAIL noops_no_writes: got %0d expected 0", wr_addr_log.size());
        end
    endtask

    task automatic test_ignore();
        clear_logs();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h09);
        step();
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 4'h1 || wr_data_log[0] !== 8'h09 || tx_log.size() != 0) begin
            errors++;
            $display("FAIL ignore_then_write: got wr=%0d tx=%0d expected one write 1/09",
                     wr_addr_log.size(), tx_log.size());
        end
    endtask

    task automatic test_reset_midcmd();
        bit ok;
        clear_logs();
        send_byte(8'hCC);
        send_byte(8'h05);
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++;
        if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, RF_WR_DATA} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 000", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, RF_WR_DATA});
        end
        clear_logs();
        send_byte(8'h07);
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (wr_addr_log.size() != 0 || rd_cnt != 0 || tx_log.size() != 0 || ALU_EN !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_strobes: got wr=%0d rd=%0d tx=%0d alu=%b expected 0 0 0 0",
                     wr_addr_log.size(), rd_cnt, tx_log.size(), ALU_EN);
        end
        send_byte(8'hBB);
        send_byte(8'h00);
        checks++;
        if ({RF_RD_EN, RF_ADDR} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL midrst_read: got en=%b addr=%h expected en=1 addr=0", RF_RD_EN, RF_ADDR);
        end
        step();
        RF_RD_DATA = 8'h5A;
        RF_RD_VLD  = 1'b1;
        step();
        RF_RD_VLD  = 1'b0;
        wait_tx(1, 50, ok);
        checks++;
        if (!ok || tx_log[0] !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_tx: got ok=%0d byte=%h expected 5a", ok, ok ? tx_log[0] : 8'h00);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (excl_viol != 0 || busy_viol != 0) begin
            errors++;
            $display("FAIL protocol: got excl=%0d busy=%0d expected 0 0", excl_viol, busy_viol);
        end
    endtask

    initial begin
        RST         = 1'b1;
        RX_P_DATA   = 8'h00;
        RX_D_VLD    = 1'b0;
        RF_RD_DATA  = 8'h00;
        RF_RD_VLD   = 1'b0;
        ALU_OUT     = 16'h0000;
        ALU_OUT_VLD = 1'b0;
        TX_BUSY     = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_alu_noops();
        test_ignore();
        test_reset_midcmd();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_frame_decoder.md
CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of the UART data path.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 CLK  in  1  single clock for all logic.
REQ-004 RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 RX_P_DATA  in  DATA_WIDTH  received byte from UART RX, valid only when RX_D_VLD=1.
REQ-006 RX_D_VLD  in  1  one-cycle pulse per received byte.
REQ-007 RF_WR_EN  out  1  register-file write strobe, one cycle.
REQ-008 RF_RD_EN  out  1  register-file read strobe, one cycle.
REQ-009 RF_ADDR  out  ADDR_WIDTH  register-file address.
REQ-010 RF_WR_DATA  out  DATA_WIDTH  register-file write data.
REQ-011 RF_RD_DATA  in  DATA_WIDTH  read data, valid when RF_RD_VLD=1.
REQ-012 RF_RD_VLD  in  1  read-data-valid pulse.
REQ-013 ALU_EN  out  1  ALU operation enable.
REQ-014 ALU_FUN  out  4  ALU function code.
REQ-015 ALU_OUT  in  2*DATA_WIDTH  ALU result, valid when ALU_OUT_VLD=1.
REQ-016 ALU_OUT_VLD  in  1  ALU result-valid pulse.
REQ-017 TX_P_DATA  out  DATA_WIDTH  byte to UART TX.
REQ-018 TX_D_VLD  out  1  one-cycle transmit request.
REQ-019 TX_BUSY  in  1  UART TX busy flag.

Function
REQ-020 SHALL decode command byte in IDLE: 0xAA=RF write, 0xBB=RF read, 0xCC=ALU with operands, 0xDD=ALU no operands; any other value ignored, stay IDLE.
REQ-021 SHALL use FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_B0, TX_B0_WAIT, TX_B1.
REQ-022 0xAA: WR_ADDR latches RX_P_DATA[ADDR_WIDTH-1:0] (upper bits ignored); WR_DATA byte -> RF_WR_EN=1 for exactly one cycle, the cycle after RX_D_VLD, with RF_ADDR/RF_WR_DATA, then IDLE; no TX response.
REQ-023 0xBB: RD_ADDR byte -> RF_RD_EN=1 one cycle next cycle with RF_ADDR, enter RD_WAIT; on RF_RD_VLD latch RF_RD_DATA, go TX_B1 (single-byte response).
REQ-024 0xCC: OP_A byte -> RF write addr 0; OP_B byte -> RF write addr 1; then FUN.
REQ-025 0xDD: go directly to FUN.
REQ-026 FUN byte -> ALU_FUN=RX_P_DATA[3:0], ALU_EN=1 held through ALU_WAIT until cycle ALU_OUT_VLD=1; latch ALU_OUT; ALU_EN=0 next cycle; go TX_B0.
REQ-027 TX_B0: when TX_BUSY=0, TX_P_DATA=result[7:0], TX_D_VLD=1 one cycle; enter TX_B0_WAIT.
REQ-028 TX_B0_WAIT: wait until TX_BUSY seen 1 then 0; enter TX_B1.
REQ-029 TX_B1: when TX_BUSY=0, TX_P_DATA=high byte (ALU) or read byte (RF), TX_D_VLD=1 one cycle; return IDLE.
REQ-030 RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state SHALL be dropped without side effects.
REQ-031 No timeout: wait states persist until their valid input arrives or RST.
REQ-032 RF_WR_EN, RF_RD_EN, TX_D_VLD SHALL never assert simultaneously.
REQ-033 TX_P_DATA SHALL remain stable while TX_D_VLD=1 and until the next transmit request.

Reset
REQ-034 RST=1 at a CLK edge SHALL force IDLE, all outputs 0, latched address/result 0, regardless of state.
REQ-035 Command in progress at reset SHALL be abandoned; no strobe issued after RST deasserts until a new command byte.

Verification
REQ-036 Bytes 0xAA,0x05,0x77 -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=0x77; no TX_D_VLD.
REQ-037 Bytes 0xBB,0x02, RF returns 0x3C -> one RF_RD_EN with RF_ADDR=2, then single TX byte 0x3C.
REQ-038 Bytes 0xCC,0x05,0x03,0x01, ALU_OUT=0x0008 -> RF writes (0,0x05),(1,0x03), ALU_FUN=1, TX bytes 0x08 then 0x00, second only after TX_BUSY 1->0.
REQ-039 Bytes 0xDD,0x02, ALU_OUT=0x1234 -> no RF writes, TX 0x34 then 0x12.
REQ-040 Byte 0x55, then 0xAA,0x01,0x09 -> 0x55 ignored; write addr 1 data 0x09.
REQ-041 RST pulse after 0xCC,0x05 -> no further strobes; subsequent 0xBB,0x00 decoded normally.
